counter_months: RTL and testbench

//   BCD month counter (01..12) for the calendar chain. It consumes the one-cycle

---
 rtl/counter_months.sv | 174 +++++++++++++++++
 tb/tb_counter_months.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/counter_months.sv
// ---------------------------------------------------------------------------
// counter_months
//   BCD month counter (01..12) for the calendar chain.
//   - Run mode advances one month per tick_month pulse and emits a one-cycle
//     tick_year on the 12 -> 01 rollover.
//   - Set mode steps the month up or down by one per cycle, with wrap-around
//     in both directions and no tick_year.
//   - max_days reports 28/29/30/31 for the current month and BCD year,
//     combinationally, so the day counter sees it in the same cycle.
//
// Optional feature macro: GREGORIAN_LEAP_EN
//   defined   : full Gregorian century rule (2000 leap, 2100 not leap)
//   undefined : leap = (yy % 4 == 0); adequate for years 2000-2099
//
// Ports
//   clk            in   1  system clock, rising edge
//   rst            in   1  synchronous reset, active-high
//   mode_month     in   1  1 = run (count on tick_month), 0 = set (up/down)
//   up             in   1  set-mode increment, one step per asserted cycle
//   down           in   1  set-mode decrement, one step per asserted cycle
//   tick_month     in   1  one-cycle pulse from the day counter
//   year_unit      in   4  BCD year digit x1
//   year_ten       in   4  BCD year digit x10
//   year_hundred   in   4  BCD year digit x100
//   year_thousand  in   4  BCD year digit x1000
//   month_unit     out  4  BCD month units, registered
//   month_ten      out  4  BCD month tens (0 or 1), registered
//   max_days       out  5  days in the current month, combinational
//   tick_year      out  1  registered one-cycle rollover pulse (run mode)
// ---------------------------------------------------------------------------
module counter_months #(
  parameter logic [3:0] RST_MONTH_UNIT = 4'd1,
  parameter logic [3:0] RST_MONTH_TEN  = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_month,
  input  logic       up,
  input  logic       down,
  input  logic       tick_month,
  input  logic [3:0] year_unit,
  input  logic [3:0] year_ten,
  input  logic [3:0] year_hundred,
  input  logic [3:0] year_thousand,
  output logic [3:0] month_unit,
  output logic [3:0] month_ten,
  output logic [4:0] max_days,
  output logic       tick_year
);

  logic [3:0] r_month_unit;
  logic [3:0] r_month_ten;
  logic       r_tick_year;

  logic       w_legal;
  logic       w_is_12;
  logic       w_is_01;
  logic [3:0] w_inc_unit;
  logic [3:0] w_inc_ten;
  logic [3:0] w_dec_unit;
  logic [3:0] w_dec_ten;

  logic [6:0] w_yy;
  logic [6:0] w_cc;
  logic       w_leap;

  // Month is legal only for 01..09 and 10..12.
  assign w_legal = ((r_month_ten == 4'd0) && (r_month_unit >= 4'd1) && (r_month_unit <= 4'd9)) ||
                   ((r_month_ten == 4'd1) && (r_month_unit <= 4'd2));
  assign w_is_12 = (r_month_ten == 4'd1) && (r_month_unit == 4'd2);
  assign w_is_01 = (r_month_ten == 4'd0) && (r_month_unit == 4'd1);

  // Increment: an illegal value or 12 both land on 01, so the month can never
  // leave the legal range after a step.
  always_comb begin
    w_inc_unit = r_month_unit;
    w_inc_ten  = r_month_ten;
    if (!w_legal || w_is_12) begin
      w_inc_unit = 4'd1;
      w_inc_ten  = 4'd0;
    end else if (r_month_unit == 4'd9) begin
      w_inc_unit = 4'd0;
      w_inc_ten  = r_month_ten + 4'd1;
    end else begin
      w_inc_unit = r_month_unit + 4'd1;
    end
  end

  // Decrement: an illegal value or 01 both land on 12.
  always_comb begin
    w_dec_unit = r_month_unit;
    w_dec_ten  = r_month_ten;
    if (!w_legal || w_is_01) begin
      w_dec_unit = 4'd2;
      w_dec_ten  = 4'd1;
    end else if (r_month_unit == 4'd0) begin
      w_dec_unit = 4'd9;
      w_dec_ten  = 4'd0;
    end else begin
      w_dec_unit = r_month_unit - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_month_unit <= RST_MONTH_UNIT;
      r_month_ten  <= RST_MONTH_TEN;
      r_tick_year  <= 1'b0;
    end else if (mode_month) begin
      // Run mode: up/down are ignored.
      r_tick_year <= 1'b0;
      if (tick_month) begin
        if (w_is_12) begin
          r_month_unit <= 4'd1;
          r_month_ten  <= 4'd0;
          r_tick_year  <= 1'b1;
        end else begin
          r_month_unit <= w_inc_unit;
          r_month_ten  <= w_inc_ten;
        end
      end
    end else begin
      // Set mode: tick_month is ignored and no year tick is ever produced.
      r_tick_year <= 1'b0;
      case ({up, down})
        2'b10: begin
          r_month_unit <= w_inc_unit;
          r_month_ten  <= w_inc_ten;
        end
        2'b01: begin
          r_month_unit <= w_dec_unit;
          r_month_ten  <= w_dec_ten;
        end
        default: begin
          r_month_unit <= r_month_unit;
          r_month_ten  <= r_month_ten;
        end
      endcase
    end
  end

  // Two-digit BCD pairs to binary; digits are guaranteed 0..9 so 0..99 fits.
  assign w_yy = ({3'b000, year_ten}      * 7'd10) + {3'b000, year_unit};
  assign w_cc = ({3'b000, year_thousand} * 7'd10) + {3'b000, year_hundred};

`ifdef GREGORIAN_LEAP_EN
  // Century years are leap only when the century number is divisible by 4.
  assign w_leap = ((w_yy != 7'd0) && ((w_yy % 7'd4) == 7'd0)) ||
                  ((w_yy == 7'd0) && ((w_cc % 7'd4) == 7'd0));
`else
  // Simple 4-year rule; the century digits do not affect the result.
  logic w_unused_cc;
  assign w_unused_cc = ^w_cc;
  assign w_leap      = ((w_yy % 7'd4) == 7'd0);
`endif

  always_comb begin
    max_days = 5'd31;
    if (w_legal) begin
      if ((r_month_ten == 4'd0) && (r_month_unit == 4'd2)) begin
        max_days = w_leap ? 5'd29 : 5'd28;
      end else if (((r_month_ten == 4'd0) &&
                    ((r_month_unit == 4'd4) || (r_month_unit == 4'd6) || (r_month_unit == 4'd9))) ||
                   ((r_month_ten == 4'd1) && (r_month_unit == 4'd1))) begin
        max_days = 5'd30;
      end
    end
  end

  assign month_unit = r_month_unit;
  assign month_ten  = r_month_ten;
  assign tick_year  = r_tick_year;

endmodule

// File: tb/tb_counter_months.sv
module tb_counter_months;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (default reset value 01)
  logic       rst, mode_month, up, down, tick_month;
  logic [15:0] year;
  logic [3:0] month_unit, month_ten;
  logic [4:0] max_days;
  logic       tick_year;

  counter_months dut (
    .clk(clk), .rst(rst), .mode_month(mode_month), .up(up), .down(down),
    .tick_month(tick_month),
    .year_unit(year[3:0]), .year_ten(year[7:4]),
    .year_hundred(year[11:8]), .year_thousand(year[15:12]),
    .month_unit(month_unit), .month_ten(month_ten),
    .max_days(max_days), .tick_year(tick_year)
  );

  // Second DUT reset into the illegal month 13 to exercise recovery
  logic       b_rst, b_mode, b_up, b_down, b_tick;
  logic [3:0] b_unit, b_ten;
  logic [4:0] b_max;
  logic       b_ty;

  counter_months #(.RST_MONTH_UNIT(4'd3), .RST_MONTH_TEN(4'd1)) dut_bad (
    .clk(clk), .rst(b_rst), .mode_month(b_mode), .up(b_up), .down(b_down),
    .tick_month(b_tick),
    .year_unit(4'd3), .year_ten(4'd2), .year_hundred(4'd0), .year_thousand(4'd2),
    .month_unit(b_unit), .month_ten(b_ten),
    .max_days(b_max), .tick_year(b_ty)
  );

  typedef struct {
    logic        rst;
    logic        mode;
    logic        up;
    logic        down;
    logic        tick;
    logic [15:0] year;
    logic [7:0]  exp_month;   // BCD {ten, unit}
    logic [4:0]  exp_max;
    logic        exp_ty;
  } vec_t;

  vec_t vecs [0:79];
  int   nvec = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic r, input logic m, input logic u, input logic d,
                     input logic t, input logic [15:0] y, input logic [7:0] em,
                     input logic [4:0] emax, input logic ety);
    vecs[nvec].rst = r;  vecs[nvec].mode = m; vecs[nvec].up = u;
    vecs[nvec].down = d; vecs[nvec].tick = t; vecs[nvec].year = y;
    vecs[nvec].exp_month = em; vecs[nvec].exp_max = emax; vecs[nvec].exp_ty = ety;
    nvec++;
  endtask

  task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got month=%02h max=%0d ty=%0b, required month=%02h max=%0d ty=%0b",
               name, got[13:6], got[5:1], got[0], exp[13:6], exp[5:1], exp[0]);
    end else begin
      $display("ok   %s: month=%02h max=%0d ty=%0b", name, got[13:6], got[5:1], got[0]);
    end
  endtask

  task automatic bad_step(input string name, input logic r, input logic m,
                          input logic u, input logic d, input logic t,
                          input logic [7:0] em, input logic [4:0] emax, input logic ety);
    b_rst = r; b_mode = m; b_up = u; b_down = d; b_tick = t;
    @(posedge clk); #1;
    check(name, {b_ten, b_unit, b_max, b_ty}, {em, emax, ety});
  endtask

  logic [4:0] exp_2100;
  logic [7:0] run_month [0:10];
  logic [4:0] run_max   [0:10];

  initial begin
`ifdef GREGORIAN_LEAP_EN
    exp_2100 = 5'd28;
`else
    exp_2100 = 5'd29;
`endif
    run_month = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h10, 8'h11, 8'h12};
    run_max   = '{5'd28, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31};

    // rst mode up down tick year  month max ty
    add(1, 1, 0, 0, 0, 16'h2023, 8'h01, 5'd31, 0);            // reset
    for (int i = 0; i < 11; i++)
      add(0, 1, 0, 0, 1, 16'h2023, run_month[i], run_max[i], 0);
    add(0, 1, 0, 0, 1, 16'h2023, 8'h01, 5'd31, 1);            // 12 -> 01 rollover
    add(0, 1, 0, 0, 0, 16'h2023, 8'h01, 5'd31, 0);            // pulse is one cycle
    add(0, 1, 0, 0, 1, 16'h2023, 8'h02, 5'd28, 0);
    add(0, 1, 0, 0, 0, 16'h2024, 8'h02, 5'd29, 0);            // leap 2024
    add(0, 1, 0, 0, 0, 16'h2023, 8'h02, 5'd28, 0);
    add(0, 1, 0, 0, 0, 16'h2000, 8'h02, 5'd29, 0);            // 2000 leap in both rules
    add(0, 1, 0, 0, 0, 16'h2100, 8'h02, exp_2100, 0);         // century rule
    add(0, 0, 0, 1, 0, 16'h2023, 8'h01, 5'd31, 0);            // set mode down 02 -> 01
    add(0, 0, 0, 1, 0, 16'h2023, 8'h12, 5'd31, 0);            // 01 -> 12, no tick
    add(0, 0, 1, 0, 0, 16'h2023, 8'h01, 5'd31, 0);            // 12 -> 01, no tick
    for (int m = 2; m <= 9; m++)
      add(0, 0, 1, 0, 0, 16'h2023, 8'(m), run_max[m - 2], 0);
    add(0, 0, 1, 0, 0, 16'h2023, 8'h10, 5'd31, 0);            // 09 -> 10
    add(0, 0, 1, 1, 0, 16'h2023, 8'h10, 5'd31, 0);            // up=down=1 hold
    add(0, 0, 0, 0, 1, 16'h2023, 8'h10, 5'd31, 0);            // tick ignored in set
    add(0, 0, 0, 1, 0, 16'h2023, 8'h09, 5'd30, 0);            // 10 -> 09
    add(0, 1, 1, 0, 0, 16'h2023, 8'h09, 5'd30, 0);            // up ignored in run
    add(0, 1, 0, 0, 1, 16'h2023, 8'h10, 5'd31, 0);
    add(0, 1, 0, 0, 1, 16'h2023, 8'h11, 5'd30, 0);
    add(0, 1, 0, 0, 1, 16'h2023, 8'h12, 5'd31, 0);
    add(0, 0, 0, 0, 1, 16'h2023, 8'h12, 5'd31, 0);            // mode change: no tick
    add(1, 1, 0, 0, 1, 16'h2023, 8'h01, 5'd31, 0);            // reset beats tick at 12

    rst = 1; mode_month = 1; up = 0; down = 0; tick_month = 0; year = 16'h2023;
    b_rst = 1; b_mode = 1; b_up = 0; b_down = 0; b_tick = 0;
    @(posedge clk); #1;

    for (int i = 0; i < nvec; i++) begin
      rst = vecs[i].rst; mode_month = vecs[i].mode; up = vecs[i].up;
      down = vecs[i].down; tick_month = vecs[i].tick; year = vecs[i].year;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), {month_ten, month_unit, max_days, tick_year},
            {vecs[i].exp_month, vecs[i].exp_max, vecs[i].exp_ty});
    end

    // Illegal-month recovery on the instance reset to 13
    bad_step("bad_reset13",   1, 0, 0, 0, 0, 8'h13, 5'd31, 0);
    bad_step("bad_hold13",    0, 0, 0, 0, 0, 8'h13, 5'd31, 0);
    bad_step("bad_up13",      0, 0, 1, 0, 0, 8'h01, 5'd31, 0);
    bad_step("bad_reset13b",  1, 0, 0, 0, 0, 8'h13, 5'd31, 0);
    bad_step("bad_down13",    0, 0, 0, 1, 0, 8'h12, 5'd31, 0);
    bad_step("bad_reset13c",  1, 1, 0, 0, 0, 8'h13, 5'd31, 0);
    bad_step("bad_tick13",    0, 1, 0, 0, 1, 8'h01, 5'd31, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
